// File: rtl/vga_sync_out.sv
// vga_sync_out: VGA raster counters, syncs and blanking, with sync/blank delayed to line up with the colour returned by the object mux.
module vga_sync_out #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int PIPE_DELAY = 2,
    parameter bit SYNC_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [7:0]  redIn,
    input  logic [7:0]  greenIn,
    input  logic [7:0]  blueIn,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        drawEn,
    output logic        startOfFrame,
    output logic [7:0]  vgaR,
    output logic [7:0]  vgaG,
    output logic [7:0]  vgaB,
    output logic        vgaHS,
    output logic        vgaVS,
    output logic        vgaBlankN
);
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] H_SS   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SE   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] V_SS   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SE   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] V_LAST = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [10:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic        h_wrap, act_raw, hs_raw, vs_raw;
    logic        dly_act, dly_hs, dly_vs;
    logic [23:0] rgb_q;
    logic        hs_q, vs_q, blank_n_q;

    always_comb begin
        h_wrap  = h_cnt_q == H_LAST;
        h_cnt_d = h_wrap ? 11'd0 : h_cnt_q + 11'd1;
        v_cnt_d = !h_wrap ? v_cnt_q : (v_cnt_q == V_LAST) ? 11'd0 : v_cnt_q + 11'd1;
        act_raw = h_cnt_q < H_ACT && v_cnt_q < V_ACT;
        hs_raw  = h_cnt_q >= H_SS && h_cnt_q < H_SE;
        vs_raw  = v_cnt_q >= V_SS && v_cnt_q < V_SE;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign pixelX       = h_cnt_q;
    assign pixelY       = v_cnt_q;
    // Counters sit at (0,0) during reset, so gate the decodes to keep them low there.
    assign drawEn       = resetN && act_raw;
    assign startOfFrame = resetN && h_wrap && v_cnt_q == V_LAST;

    generate
        if (PIPE_DELAY == 0) begin : g_nodly
            assign {dly_hs, dly_vs, dly_act} = {hs_raw, vs_raw, act_raw};
        end else begin : g_dly
            logic [2:0] pipe_q [PIPE_DELAY];
            always_ff @(posedge clk or negedge resetN) begin
                if (!resetN) begin
                    pipe_q <= '{default: 3'b000};
                end else begin
                    pipe_q[0] <= {hs_raw, vs_raw, act_raw};
                    for (int i = 1; i < PIPE_DELAY; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end
            assign {dly_hs, dly_vs, dly_act} = pipe_q[PIPE_DELAY-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rgb_q     <= '0;
            hs_q      <= ~SYNC_POL;
            vs_q      <= ~SYNC_POL;
            blank_n_q <= 1'b0;
        end else begin
            rgb_q     <= dly_act ? {redIn, greenIn, blueIn} : 24'd0;
            hs_q      <= dly_hs ? SYNC_POL : ~SYNC_POL;
            vs_q      <= dly_vs ? SYNC_POL : ~SYNC_POL;
            blank_n_q <= dly_act;
        end
    end

    assign {vgaR, vgaG, vgaB} = rgb_q;
    assign vgaHS              = hs_q;
    assign vgaVS              = vs_q;
    assign vgaBlankN          = blank_n_q;
endmodule
